// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, control-field encodings and the
// E-stage control bundle carried from D to E.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_M    = 7'b0000001;

  // Branch compares share codes with sub/slt/sltu where the ALU result matches.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_BGE  = 4'b1001,
    ALU_BGEU = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_BNE  = 4'b1100,
    ALU_LUI  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_PCIMM = 2'b11
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        jalr;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
    imm_src_e    imm_src;
    logic [2:0]  addr_ctrl;
    logic        mul_div;
    logic [2:0]  mul_div_op;
  } ctrl_bundle_t;

  // DIV/DIVU/REM/REMU are the M ops with funct3[2] set.
  function automatic logic is_div(input ctrl_bundle_t c);
    return c.mul_div & c.mul_div_op[2];
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I(+M) decoder: instruction word to E control bundle and
// an illegal flag. Illegal encodings produce an all-zero bundle.
module instr_decoder
  import decode_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0]  instr_i,
  output ctrl_bundle_t ctrl_o,
  output logic         illegal_o
);

  logic [6:0]   w_opcode;
  logic [2:0]   w_funct3;
  logic [6:0]   w_funct7;
  ctrl_bundle_t w_dec;
  logic         w_illegal;
  logic         w_unused_fields;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    unique case (w_opcode)
      OP_R: begin
        w_dec.reg_write = 1'b1;
        if (ENABLE_M && w_funct7 == F7_M) begin
          w_dec.mul_div    = 1'b1;
          w_dec.mul_div_op = w_funct3;
        end else if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
          unique case (w_funct3)
            3'b000:  w_dec.alu_ctrl = w_funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  w_dec.alu_ctrl = ALU_SLL;
            3'b010:  w_dec.alu_ctrl = ALU_SLT;
            3'b011:  w_dec.alu_ctrl = ALU_SLTU;
            3'b100:  w_dec.alu_ctrl = ALU_XOR;
            3'b101:  w_dec.alu_ctrl = w_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_dec.alu_ctrl = ALU_OR;
            default: w_dec.alu_ctrl = ALU_AND;
          endcase
        end else begin
          w_illegal = 1'b1;
        end
      end
      OP_I: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        unique case (w_funct3)
          3'b000: w_dec.alu_ctrl = ALU_ADD;
          3'b001: begin
            w_dec.alu_ctrl = ALU_SLL;
            w_illegal      = (w_funct7 != F7_BASE);
          end
          3'b010: w_dec.alu_ctrl = ALU_SLT;
          3'b011: w_dec.alu_ctrl = ALU_SLTU;
          3'b100: w_dec.alu_ctrl = ALU_XOR;
          3'b101: begin
            w_dec.alu_ctrl = w_funct7[5] ? ALU_SRA : ALU_SRL;
            w_illegal      = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          3'b110:  w_dec.alu_ctrl = ALU_OR;
          default: w_dec.alu_ctrl = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = RES_MEM;
        w_dec.addr_ctrl  = w_funct3;
        w_illegal        = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        w_dec.mem_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.imm_src   = IMM_S;
        w_dec.addr_ctrl = w_funct3;
        w_illegal       = (w_funct3 > 3'b010);
      end
      OP_BRANCH: begin
        w_dec.branch  = 1'b1;
        w_dec.imm_src = IMM_B;
        unique case (w_funct3)
          3'b000:  w_dec.alu_ctrl = ALU_SUB;
          3'b001:  w_dec.alu_ctrl = ALU_BNE;
          3'b100:  w_dec.alu_ctrl = ALU_SLT;
          3'b101:  w_dec.alu_ctrl = ALU_BGE;
          3'b110:  w_dec.alu_ctrl = ALU_SLTU;
          3'b111:  w_dec.alu_ctrl = ALU_BGEU;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.result_src = RES_PC4;
        w_dec.imm_src    = IMM_J;
      end
      OP_JALR: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jump       = 1'b1;
        w_dec.jalr       = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = RES_PC4;
      end
      OP_LUI: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.imm_src   = IMM_U;
        w_dec.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.imm_src    = IMM_U;
        w_dec.result_src = RES_PCIMM;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Squash the whole bundle so an illegal op can never write state or start the divider.
  assign ctrl_o    = w_illegal ? '0 : w_dec;
  assign illegal_o = w_illegal;

endmodule

// File: rtl/decode_ctrl_stage.sv
// ID/EX control register: latches the decoded bundle into E with flush/stall
// priority and back-pressures D while a multi-cycle DIV/REM occupies E.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit ENABLE_M   = 1'b1,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        valid_e_o,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        JALRInstrE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  ImmSrcE,
  output logic [2:0]  AddressingControlE,
  output logic        MulDivE,
  output logic [2:0]  MulDivOpE,
  output logic        illegal_e_o,
  output logic        busy_o
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("decode_ctrl_stage: only DATA_WIDTH=32 is supported");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 32) begin : g_bad_div
    $error("decode_ctrl_stage: DIV_CYCLES must be in 1..32");
  end

  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  ctrl_bundle_t w_dec;
  logic         w_dec_illegal;
  logic         w_busy;
  logic         w_ready;

  ctrl_bundle_t r_ctrl;
  logic         r_valid;
  logic         r_illegal;
  logic [4:0]   r_cnt;

  instr_decoder #(
    .ENABLE_M (ENABLE_M)
  ) u_decoder (
    .instr_i   (instr_i),
    .ctrl_o    (w_dec),
    .illegal_o (w_dec_illegal)
  );

  assign w_busy  = (r_cnt != 5'd0);
  assign w_ready = rst_n & ~stall_i & ~w_busy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= 5'd0;
    end else if (flush_i) begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= 5'd0;
    end else if (stall_i || w_busy) begin
      // E holds, but the divider keeps counting down regardless of the stall.
      if (w_busy) begin
        r_cnt <= r_cnt - 5'd1;
      end
    end else if (valid_i) begin
      r_ctrl    <= w_dec;
      r_valid   <= 1'b1;
      r_illegal <= w_dec_illegal;
      r_cnt     <= is_div(w_dec) ? DIV_LOAD : 5'd0;
    end else begin
      r_ctrl    <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  assign ready_o            = w_ready;
  assign busy_o             = w_busy;
  assign valid_e_o          = r_valid;
  assign illegal_e_o        = r_illegal;
  assign RegWriteE          = r_ctrl.reg_write;
  assign MemWriteE          = r_ctrl.mem_write;
  assign JumpE              = r_ctrl.jump;
  assign BranchE            = r_ctrl.branch;
  assign ALUSrcE            = r_ctrl.alu_src;
  assign JALRInstrE         = r_ctrl.jalr;
  assign ResultSrcE         = r_ctrl.result_src;
  assign ALUControlE        = r_ctrl.alu_ctrl;
  assign ImmSrcE            = r_ctrl.imm_src;
  assign AddressingControlE = r_ctrl.addr_ctrl;
  assign MulDivE            = r_ctrl.mul_div;
  assign MulDivOpE          = r_ctrl.mul_div_op;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: default build, an ENABLE_M=0 build and
// a DIV_CYCLES=1 build all driven by the same D-stage stimulus.
module tb_decode_ctrl_stage;

  localparam logic [31:0] I_ADD   = 32'h00208033;
  localparam logic [31:0] I_SRAI  = 32'h4020D093;
  localparam logic [31:0] I_AUIPC = 32'h00000097;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_MUL   = 32'h022080B3;
  localparam logic [31:0] I_DIV   = 32'h0220C0B3;
  localparam logic [31:0] I_ONES  = 32'hFFFFFFFF;
  localparam logic [31:0] I_LDBAD = 32'h0000B003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid, stall, flush;

  logic       ready, valid_e, reg_write, mem_write, jump, branch, alu_src, jalr;
  logic [1:0] result_src;
  logic [3:0] alu_ctrl;
  logic [2:0] imm_src, addr_ctrl, mul_div_op;
  logic       mul_div, illegal, busy;

  logic       n_ready, n_valid_e, n_reg_write, n_mem_write, n_jump, n_branch, n_alu_src, n_jalr;
  logic [1:0] n_result_src;
  logic [3:0] n_alu_ctrl;
  logic [2:0] n_imm_src, n_addr_ctrl, n_mul_div_op;
  logic       n_mul_div, n_illegal, n_busy;

  logic       d_ready, d_valid_e, d_reg_write, d_mem_write, d_jump, d_branch, d_alu_src, d_jalr;
  logic [1:0] d_result_src;
  logic [3:0] d_alu_ctrl;
  logic [2:0] d_imm_src, d_addr_ctrl, d_mul_div_op;
  logic       d_mul_div, d_illegal, d_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .valid_i(valid), .ready_o(ready),
    .stall_i(stall), .flush_i(flush), .valid_e_o(valid_e), .RegWriteE(reg_write),
    .MemWriteE(mem_write), .JumpE(jump), .BranchE(branch), .ALUSrcE(alu_src),
    .JALRInstrE(jalr), .ResultSrcE(result_src), .ALUControlE(alu_ctrl),
    .ImmSrcE(imm_src), .AddressingControlE(addr_ctrl), .MulDivE(mul_div),
    .MulDivOpE(mul_div_op), .illegal_e_o(illegal), .busy_o(busy)
  );

  decode_ctrl_stage #(.ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .valid_i(valid), .ready_o(n_ready),
    .stall_i(stall), .flush_i(flush), .valid_e_o(n_valid_e), .RegWriteE(n_reg_write),
    .MemWriteE(n_mem_write), .JumpE(n_jump), .BranchE(n_branch), .ALUSrcE(n_alu_src),
    .JALRInstrE(n_jalr), .ResultSrcE(n_result_src), .ALUControlE(n_alu_ctrl),
    .ImmSrcE(n_imm_src), .AddressingControlE(n_addr_ctrl), .MulDivE(n_mul_div),
    .MulDivOpE(n_mul_div_op), .illegal_e_o(n_illegal), .busy_o(n_busy)
  );

  decode_ctrl_stage #(.DIV_CYCLES(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .valid_i(valid), .ready_o(d_ready),
    .stall_i(stall), .flush_i(flush), .valid_e_o(d_valid_e), .RegWriteE(d_reg_write),
    .MemWriteE(d_mem_write), .JumpE(d_jump), .BranchE(d_branch), .ALUSrcE(d_alu_src),
    .JALRInstrE(d_jalr), .ResultSrcE(d_result_src), .ALUControlE(d_alu_ctrl),
    .ImmSrcE(d_imm_src), .AddressingControlE(d_addr_ctrl), .MulDivE(d_mul_div),
    .MulDivOpE(d_mul_div_op), .illegal_e_o(d_illegal), .busy_o(d_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = 32'h0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("rst_outputs", {valid_e, reg_write, mem_write, jump, branch, alu_src, jalr,
                          result_src, alu_ctrl, imm_src, addr_ctrl, mul_div, mul_div_op,
                          illegal, busy}, 32'h0);
    check("rst_ready_low", ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_high", ready, 1'b1);

    // add x0,x1,x2
    instr = I_ADD; valid = 1'b1;
    tick();
    check("add_fields", {valid_e, reg_write, alu_ctrl, alu_src, result_src, illegal},
          {1'b1, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0});

    instr = I_SRAI;
    tick();
    check("srai_alu", alu_ctrl, 4'b1011);
    check("srai_imm", {imm_src, alu_src}, {3'b000, 1'b1});

    instr = I_AUIPC;
    tick();
    check("auipc", {result_src, imm_src, reg_write}, {2'b11, 3'b100, 1'b1});

    instr = I_LUI;
    tick();
    check("lui", {alu_ctrl, imm_src, result_src}, {4'b1111, 3'b100, 2'b00});

    instr = I_JAL;
    tick();
    check("jal", {jump, jalr, reg_write, result_src, imm_src}, {1'b1, 1'b0, 1'b1, 2'b10, 3'b011});

    instr = I_JALR;
    tick();
    check("jalr", {jump, jalr, alu_src, result_src}, {1'b1, 1'b1, 1'b1, 2'b10});

    instr = I_BNE;
    tick();
    check("bne", {branch, reg_write, alu_ctrl, imm_src}, {1'b1, 1'b0, 4'b1100, 3'b010});

    instr = I_SW;
    tick();
    check("sw", {mem_write, reg_write, imm_src, addr_ctrl}, {1'b1, 1'b0, 3'b001, 3'b010});

    // MUL: M op that never occupies the divider; illegal without ENABLE_M
    instr = I_MUL;
    tick();
    check("mul_fields", {mul_div, mul_div_op, busy, reg_write}, {1'b1, 3'b000, 1'b0, 1'b1});
    check("mul_nom_illegal", {n_valid_e, n_illegal, n_reg_write, n_mem_write, n_mul_div},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    // DIV with DIV_CYCLES=8: 7 busy cycles, 8 cycles resident in E
    instr = I_DIV;
    tick();
    instr = I_ADD;
    check("div_c1", {busy, ready, mul_div, mul_div_op}, {1'b1, 1'b0, 1'b1, 3'b100});
    check("div_d1_nobusy", {d_busy, d_ready, d_mul_div}, {1'b0, 1'b1, 1'b1});
    for (int c = 2; c <= 7; c++) begin
      tick();
      check($sformatf("div_c%0d", c), {busy, ready, valid_e, mul_div_op}, {1'b1, 1'b0, 1'b1, 3'b100});
    end
    tick();
    check("div_c8", {busy, ready, valid_e, mul_div, mul_div_op}, {1'b0, 1'b1, 1'b1, 1'b1, 3'b100});
    tick();
    check("div_next", {valid_e, mul_div, reg_write, alu_ctrl}, {1'b1, 1'b0, 1'b1, 4'b0000});

    // DIV flushed in its third cycle
    instr = I_DIV;
    tick();
    instr = I_ADD;
    tick();
    tick();
    check("divf_c3_busy", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("divf_bubble", {busy, valid_e, mul_div, ready}, {1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    check("divf_accept", {valid_e, mul_div, reg_write, alu_ctrl}, {1'b1, 1'b0, 1'b1, 4'b0000});

    // Illegal encodings
    instr = I_ONES;
    tick();
    check("ill_ones", {valid_e, illegal, reg_write, mem_write, jump, branch},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    instr = I_LDBAD;
    tick();
    check("ill_load011", {valid_e, illegal, reg_write, mem_write}, {1'b1, 1'b1, 1'b0, 1'b0});

    // Stall holds E for three cycles, then flush beats stall
    instr = I_SW;
    tick();
    check("stall_pre", {illegal, mem_write}, {1'b0, 1'b1});
    stall = 1'b1; instr = I_ADD;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("stall_c%0d", c), {valid_e, mem_write, reg_write, addr_ctrl, ready},
            {1'b1, 1'b1, 1'b0, 3'b010, 1'b0});
    end
    flush = 1'b1;
    tick();
    check("flush_over_stall", {valid_e, mem_write, reg_write}, {1'b0, 1'b0, 1'b0});
    flush = 1'b0; stall = 1'b0; valid = 1'b0;
    tick();
    check("idle_bubble", {valid_e, ready}, {1'b0, 1'b1});

    // Reset in the middle of a DIV
    instr = I_DIV; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    check("rdiv_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("rdiv_cleared", {busy, valid_e, mul_div, mul_div_op}, {1'b0, 1'b0, 1'b0, 3'b000});
    rst_n = 1'b1;
    #1;
    check("rdiv_ready", ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered successor to the combinational decoder: decodes a full 32-bit instruction in D and presents a registered control bundle to E, acting as the ID/EX control register.
- Adds AUIPC, optional M-extension decode, illegal-instruction detection, stall/flush handling, and a multi-cycle DIV/REM occupancy counter that back-pressures fetch/decode.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported and elaboration fails otherwise.
- ENABLE_M, 1, decode the M extension; when 0, M encodings are illegal.
- DIV_CYCLES, 8, E-stage occupancy of DIV/DIVU/REM/REMU; legal range 1..32.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_i  in  32  instruction in D
- valid_i  in  1  instr_i is valid
- ready_o  out  1  stage accepts instr_i this cycle
- stall_i  in  1  hazard unit holds E contents
- flush_i  in  1  branch/jump redirect; kill E contents
- valid_e_o  out  1  E holds a live instruction
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JALRInstrE  out  1 each  as decoded
- ResultSrcE  out  2  00 ALU, 01 mem, 10 PC+4, 11 PC+imm (AUIPC)
- ALUControlE  out  4  ALU operation code
- ImmSrcE  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- AddressingControlE  out  3  funct3 for loads/stores, 000 otherwise
- MulDivE  out  1  M-extension operation
- MulDivOpE  out  3  funct3 of the M operation
- illegal_e_o  out  1  E holds an illegal instruction
- busy_o  out  1  divider occupancy in progress

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, the counter is 0, and ready_o is 1 in the following cycle.
- Decode is combinational from instr_i and is latched at the clk edge. Latency is 1 cycle from D to E.
- ALUControl codes:
  - add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1011, lui 1111.
  - Branches: beq 0001, bne 1100, blt 0101, bge 1001, bltu 0110, bgeu 1010.
- Opcodes decoded: R 0110011, I-ALU 0010011 (includes slti/sltiu), load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Illegal cases: unknown opcode; R-type funct7 not 0000000/0100000 (or 0000001 when ENABLE_M); shift-immediate funct7 invalid; branch funct3 010/011; load funct3 011/110/111; store funct3 >010.
  - An illegal instruction enters E with valid_e_o=1, illegal_e_o=1, RegWriteE=MemWriteE=JumpE=BranchE=0.
- ready_o = rst_n & ~stall_i & ~busy_o.
- Register update priority, highest first:
  1. Reset.
  2. flush_i: bubble, all control outputs 0, counter cleared.
  3. stall_i or busy_o: hold.
  4. valid_i & ready_o: load decode.
  5. Otherwise: bubble.
- Divider counter: when an M op with funct3[2]=1 loads, the counter is set to DIV_CYCLES-1.
  - busy_o = (counter != 0). The counter decrements by 1 each cycle, also while stall_i is high.
  - E holds the DIV for DIV_CYCLES cycles total.
  - DIV_CYCLES=1 produces no busy.
  - MUL ops (funct3[2]=0) never assert busy.
- flush_i mid-busy clears the counter immediately; busy_o=0 the next cycle.
- Simultaneous flush_i and stall_i: flush wins.
- Reset mid-busy clears everything.

Decomposition:
- Package decode_pkg holds:
  - opcode localparams;
  - ALU-control, ImmSrc and ResultSrc enums;
  - typedef ctrl_bundle_t, a packed struct of every E control field.
- Sub-module instr_decoder: purely combinational, maps instr_i to ctrl_bundle_t plus an illegal flag.
- decode_ctrl_stage instantiates instr_decoder and holds the register, priority logic and divider counter.

Test Plan:
- Reset, then instr_i=0x00208033 (add x0,x1,x2), valid_i=1: next cycle valid_e_o=1, RegWriteE=1, ALUControlE=0000, ALUSrcE=0, ResultSrcE=00.
- Load 0x4020D093 (srai x1,x1,2), then 0x00000097 (auipc): ALUControlE=1011, ImmSrcE=000; then ResultSrcE=11, ImmSrcE=100.
- DIV 0x0220C0B3 with DIV_CYCLES=8: busy_o high 7 cycles, ready_o low 7 cycles, MulDivOpE=100 held 8 cycles; next instruction accepted on cycle 8.
- Same DIV with flush_i at cycle 3: busy_o=0 and valid_e_o=0 next cycle; a pending valid_i is accepted the cycle after.
- Illegal 0xFFFFFFFF, and 0x0000B003 (load funct3 011): illegal_e_o=1, RegWriteE=0, MemWriteE=0. With ENABLE_M=0, 0x022080B3 (mul) is also illegal.
- stall_i=1 for 3 cycles with a new instr_i present: E outputs unchanged and ready_o=0. Then flush_i and stall_i both high: bubble.
